// File: rtl/cache_way_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_way_mux_if
// Purpose  : Beat-in / result-out bus of the cache way-select stage.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_way_mux_if #(
    parameter int W    = 64,
    parameter int WAYS = 4
);
    localparam int SEL_W = $clog2(WAYS);

    logic                  in_valid;
    logic                  in_ready;
    logic [WAYS*W-1:0]     in_data;
    logic [WAYS-1:0]       in_hit;
    logic                  out_valid;
    logic                  out_ready;
    logic [W-1:0]          out_data;
    logic [SEL_W-1:0]      out_way;
    logic                  out_miss;
    logic                  out_multi;

    modport master (
        output in_valid, in_data, in_hit, out_ready,
        input  in_ready, out_valid, out_data, out_way, out_miss, out_multi
    );

    modport slave (
        input  in_valid, in_data, in_hit, out_ready,
        output in_ready, out_valid, out_data, out_way, out_miss, out_multi
    );
endinterface
`default_nettype wire

// File: rtl/cache_way_mux.sv
`default_nettype none
// ============================================================================
// Module   : cache_way_mux
// Purpose  : Registered way select (lowest hitting way) with 2-entry output
//            buffer and saturating hit/miss statistics.
// Revision : 1.0 - initial release
// ============================================================================
module cache_way_mux #(
    parameter int W     = 64,
    parameter int WAYS  = 4,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    cache_way_mux_if.slave        bus,
    input  wire logic             clr_cnt,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);
    localparam int SEL_W = $clog2(WAYS);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [WAYS-1:0]  c_hit_one = WAYS'(1);

    logic [W-1:0]       w_sel_data;
    logic [SEL_W-1:0]   w_sel_way;
    logic               w_any_hit;
    logic               w_multi;
    logic               w_push;
    logic               w_pop;

    logic [W-1:0]       r_data [2];
    logic [SEL_W-1:0]   r_way  [2];
    logic [1:0]         r_miss;
    logic [1:0]         r_multi;
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    // Scan from the top down so the lowest hitting way is the last to win.
    always_comb begin
        w_sel_data = '0;
        w_sel_way  = '0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (bus.in_hit[k]) begin
                w_sel_data = bus.in_data[k*W +: W];
                w_sel_way  = k[SEL_W-1:0];
            end
        end
    end

    assign w_any_hit = |bus.in_hit;
    assign w_multi   = |(bus.in_hit & (bus.in_hit - c_hit_one));

    // in_ready depends only on the registered fill level, never on out_ready.
    assign bus.in_ready  = (r_count != 2'd2);
    assign bus.out_valid = (r_count != 2'd0);
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    assign bus.out_data  = r_data[r_rd_ptr];
    assign bus.out_way   = r_way[r_rd_ptr];
    assign bus.out_miss  = r_miss[r_rd_ptr];
    assign bus.out_multi = r_multi[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_way[0]  <= '0;
            r_way[1]  <= '0;
            r_miss    <= '0;
            r_multi   <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr]  <= w_sel_data;
                r_way[r_wr_ptr]   <= w_sel_way;
                r_miss[r_wr_ptr]  <= ~w_any_hit;
                r_multi[r_wr_ptr] <= w_multi;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A same-cycle clear discards the accepted beat from the statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (clr_cnt) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_push) begin
            if (w_any_hit) begin
                if (r_hit_cnt != c_cnt_max) r_hit_cnt <= r_hit_cnt + c_cnt_one;
            end else begin
                if (r_miss_cnt != c_cnt_max) r_miss_cnt <= r_miss_cnt + c_cnt_one;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
endmodule
`default_nettype wire
